ram1_uart_arbiter: RTL and testbench

RAM1_UART_ARBITER -- requirements
Module: ram1_uart_arbiter

---
 rtl/ram1_uart_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_ram1_uart_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram1_uart_arbiter.sv
// Arbitrates one memory requester and one UART requester onto the shared SRAM1/UART data bus.
// Latency: a memory access finishes (done_m) in the third cycle after grant; UART ops depend on the UART status lines, bounded by WAIT_MAX.
// Backpressure: requesters hold req_* until their done_* pulse; a loser waits in IDLE until the bus is free.
//
// Ports:
//   clk, rst (async, active-low)
//   req_m/we_m/addr_m/wdata_m -> rdata_m/done_m   : memory requester
//   req_u/we_u/wdata_u        -> rdata_u/done_u/err_u : UART requester
//   ram_addr1, ram_data1 (shared inout), ram1OE/ram1WE/ram1EN : SRAM1 pins (active-low strobes)
//   rdn, wrn (active-low), data_ready/tbre/tsre (active-high) : UART pins
// Build option: define ARB_ROUND_ROBIN_EN to give simultaneous requests to the
// requester not granted last; otherwise the memory requester always wins.
module ram1_uart_arbiter #(
  parameter int WAIT_MAX = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_m,
  input  logic        we_m,
  input  logic [17:0] addr_m,
  input  logic [15:0] wdata_m,
  output logic [15:0] rdata_m,
  output logic        done_m,
  input  logic        req_u,
  input  logic        we_u,
  input  logic [7:0]  wdata_u,
  output logic [7:0]  rdata_u,
  output logic        done_u,
  output logic        err_u,
  output logic [17:0] ram_addr1,
  inout  wire  [15:0] ram_data1,
  output logic        ram1OE,
  output logic        ram1WE,
  output logic        ram1EN,
  output logic        rdn,
  output logic        wrn,
  input  logic        data_ready,
  input  logic        tbre,
  input  logic        tsre
);

  // Counter only has to reach WAIT_MAX-1: the expiring cycle is the last wait cycle.
  localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);

  typedef enum logic [3:0] {
    IDLE, M_SETUP, M_ACCESS, M_DONE,
    U_RWAIT, U_RD1, U_RD2, U_WR, U_TBRE, U_TSRE, U_DONE
  } state_t;

  state_t          state_q;
  logic            we_q;
  logic [CW-1:0]   cnt_q;
  logic [15:0]     dout_q;
  logic            drv_lo_q;
  logic            drv_hi_q;
  logic            grant_m;
  logic            wait_expired;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_m_q;  // 1 when the memory requester received the most recent grant
  assign grant_m = req_m & (~req_u | ~last_m_q);
`else
  assign grant_m = req_m;
`endif

  assign wait_expired = (cnt_q == CW'(WAIT_MAX - 1));

  // Byte lanes are enabled separately so a UART transmit leaves [15:8] floating.
  assign ram_data1[7:0]  = drv_lo_q ? dout_q[7:0]  : 8'hzz;
  assign ram_data1[15:8] = drv_hi_q ? dout_q[15:8] : 8'hzz;

  // All strobes are registered: each branch sets the outputs that belong to the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      dout_q    <= '0;
      drv_lo_q  <= 1'b0;
      drv_hi_q  <= 1'b0;
      ram_addr1 <= '0;
      rdata_m   <= '0;
      rdata_u   <= '0;
      done_m    <= 1'b0;
      done_u    <= 1'b0;
      err_u     <= 1'b0;
      ram1EN    <= 1'b1;
      ram1OE    <= 1'b1;
      ram1WE    <= 1'b1;
      rdn       <= 1'b1;
      wrn       <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      last_m_q  <= 1'b0;
`endif
    end else begin
      done_m <= 1'b0;
      done_u <= 1'b0;
      err_u  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_m) begin
            we_q      <= we_m;
            ram_addr1 <= addr_m;
            dout_q    <= wdata_m;
            drv_lo_q  <= we_m;
            drv_hi_q  <= we_m;
            ram1EN    <= 1'b0;
            ram1OE    <= we_m;
            ram1WE    <= 1'b1;
            state_q   <= M_SETUP;
`ifdef ARB_ROUND_ROBIN_EN
            last_m_q  <= 1'b1;
`endif
          end else if (req_u) begin
            we_q   <= we_u;
            cnt_q  <= '0;
            dout_q <= {8'h00, wdata_u};
            if (we_u) begin
              drv_lo_q <= 1'b1;
              wrn      <= 1'b0;
              state_q  <= U_WR;
            end else begin
              state_q  <= U_RWAIT;
            end
`ifdef ARB_ROUND_ROBIN_EN
            last_m_q <= 1'b0;
`endif
          end
        end
        M_SETUP: begin
          ram1WE  <= ~we_q;
          state_q <= M_ACCESS;
        end
        M_ACCESS: begin
          if (!we_q) rdata_m <= ram_data1;
          ram1OE  <= 1'b1;
          ram1WE  <= 1'b1;
          done_m  <= 1'b1;
          state_q <= M_DONE;
        end
        M_DONE: begin
          ram1EN   <= 1'b1;
          drv_lo_q <= 1'b0;
          drv_hi_q <= 1'b0;
          state_q  <= IDLE;
        end
        U_RWAIT: begin
          if (data_ready) begin
            rdn     <= 1'b0;
            state_q <= U_RD1;
          end else if (wait_expired) begin
            done_u  <= 1'b1;
            err_u   <= 1'b1;
            state_q <= U_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        U_RD1: state_q <= U_RD2;
        U_RD2: begin
          rdata_u <= ram_data1[7:0];
          rdn     <= 1'b1;
          done_u  <= 1'b1;
          state_q <= U_DONE;
        end
        U_WR: begin
          wrn      <= 1'b1;
          drv_lo_q <= 1'b0;
          cnt_q    <= '0;
          state_q  <= U_TBRE;
        end
        U_TBRE: begin
          if (tbre) begin
            cnt_q   <= '0;
            state_q <= U_TSRE;
          end else if (wait_expired) begin
            done_u  <= 1'b1;
            err_u   <= 1'b1;
            state_q <= U_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        U_TSRE: begin
          if (tsre) begin
            done_u  <= 1'b1;
            state_q <= U_DONE;
          end else if (wait_expired) begin
            done_u  <= 1'b1;
            err_u   <= 1'b1;
            state_q <= U_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        U_DONE:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram1_uart_arbiter.sv
// Scoreboard bench for ram1_uart_arbiter: directed cases plus randomized traffic
// against an SRAM/UART device model and a reference memory array.
module tb_ram1_uart_arbiter;
  localparam int WM = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_m = 1'b0, we_m = 1'b0;
  logic [17:0] addr_m = '0;
  logic [15:0] wdata_m = '0;
  logic [15:0] rdata_m;
  logic        done_m;
  logic        req_u = 1'b0, we_u = 1'b0;
  logic [7:0]  wdata_u = '0;
  logic [7:0]  rdata_u;
  logic        done_u, err_u;
  logic [17:0] ram_addr1;
  wire  [15:0] ram_data1;
  logic        ram1OE, ram1WE, ram1EN, rdn, wrn;
  logic        data_ready = 1'b0, tbre = 1'b1, tsre = 1'b1;

  logic [15:0] sram    [0:255];
  logic [15:0] ref_mem [0:255];
  logic [7:0]  rx_byte = 8'h00;

  initial forever #5 clk = ~clk;

  ram1_uart_arbiter #(.WAIT_MAX(WM)) dut (
    .clk(clk), .rst(rst),
    .req_m(req_m), .we_m(we_m), .addr_m(addr_m), .wdata_m(wdata_m),
    .rdata_m(rdata_m), .done_m(done_m),
    .req_u(req_u), .we_u(we_u), .wdata_u(wdata_u),
    .rdata_u(rdata_u), .done_u(done_u), .err_u(err_u),
    .ram_addr1(ram_addr1), .ram_data1(ram_data1),
    .ram1OE(ram1OE), .ram1WE(ram1WE), .ram1EN(ram1EN),
    .rdn(rdn), .wrn(wrn),
    .data_ready(data_ready), .tbre(tbre), .tsre(tsre)
  );

  // SRAM answers reads while enabled with OE low; UART answers while rdn is low.
  assign ram_data1 = (!ram1EN && !ram1OE && ram1WE) ? sram[ram_addr1[7:0]] :
                     (!rdn ? {8'h00, rx_byte} : 16'hzzzz);

  typedef struct { bit we; logic [17:0] addr; logic [15:0] data; } mop_t;
  typedef struct { bit we; logic [7:0] data; int d1; int d2; } uop_t;
  typedef struct { bit rd; logic [17:0] addr; logic [15:0] v; } mexp_t;
  typedef struct { bit err; logic [7:0] v; int rdn_n; int wrn_n; } uexp_t;

  mop_t        mq[$];
  uop_t        uq[$];
  mexp_t       exp_m[$];
  uexp_t       exp_u[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  done_log[$];
  logic [7:0]  last_rx = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: expected responses are derived when the op is issued.
  task automatic issue_m(input bit we, input logic [17:0] a, input logic [15:0] d);
    mop_t  o;
    mexp_t e;
    o.we = we; o.addr = a; o.data = d;
    mq.push_back(o);
    e.rd = !we; e.addr = a;
    if (we) begin
      ref_mem[a[7:0]] = d;
      e.v = d;
    end else begin
      e.v = ref_mem[a[7:0]];
    end
    exp_m.push_back(e);
  endtask

  // d1: cycles until data_ready (rx) or tbre (tx); d2: further cycles until tsre; -1 = never.
  task automatic issue_u(input bit we, input logic [7:0] d, input int d1, input int d2);
    uop_t  o;
    uexp_t e;
    bit    err;
    o.we = we; o.data = d; o.d1 = d1; o.d2 = d2;
    uq.push_back(o);
    err = we ? (d1 < 0 || d2 < 0) : (d1 < 0);
    if (!we && !err) last_rx = d;
    e.err = err; e.v = last_rx;
    e.rdn_n = (!we && !err) ? 2 : 0;
    e.wrn_n = we ? 1 : 0;
    exp_u.push_back(e);
    if (we) exp_tx.push_back(d);
  endtask

  task automatic measure(input bit is_m, output int k);
    @(negedge clk);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(is_m ? done_m : done_u) && k < 200);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((mq.size() != 0 || uq.size() != 0 || exp_m.size() != 0 || exp_u.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("drain_in_budget", {31'b0, k < budget}, 1);
  endtask

  // SRAM write capture.
  initial forever begin
    @(negedge clk);
    if (rst && !ram1EN && !ram1WE) sram[ram_addr1[7:0]] = ram_data1;
  end

  // Memory requester: holds req_m while ops are queued, retires one per done_m.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (done_m && mq.size() != 0) mq.delete(0);
      if (mq.size() != 0) begin
        req_m = 1'b1; we_m = mq[0].we; addr_m = mq[0].addr; wdata_m = mq[0].data;
      end else begin
        req_m = 1'b0;
      end
    end
  end

  // UART requester plus UART device status model.
  initial begin
    int uc = 0, wc = 0;
    bit rd_seen = 0, wr_seen = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        uc = 0; wc = 0; rd_seen = 0; wr_seen = 0;
        data_ready = 1'b0; tbre = 1'b1; tsre = 1'b1;
        continue;
      end
      if (done_u) begin
        if (uq.size() != 0) uq.delete(0);
        uc = 0; wc = 0; rd_seen = 0; wr_seen = 0;
      end else if (req_u) begin
        uc++;
      end
      if (!rdn) rd_seen = 1;
      if (!wrn) begin
        wr_seen = 1; wc = 0;
      end else if (wr_seen) begin
        wc++;
      end
      if (uq.size() != 0) begin
        req_u = 1'b1; we_u = uq[0].we; wdata_u = uq[0].data; rx_byte = uq[0].data;
        data_ready = !uq[0].we && uq[0].d1 >= 0 && uc >= uq[0].d1 && !rd_seen;
        tbre = !wr_seen || (uq[0].d1 >= 0 && wc >= uq[0].d1);
        tsre = !wr_seen || (uq[0].d1 >= 0 && uq[0].d2 >= 0 && wc >= uq[0].d1 + uq[0].d2);
      end else begin
        req_u = 1'b0; data_ready = 1'b0; tbre = 1'b1; tsre = 1'b1;
      end
    end
  end

  // Monitor: strobe rules every cycle, scoreboard pops on each done pulse.
  initial begin
    int    we_n = 0, rdn_n = 0, wrn_n = 0;
    bit    ok;
    mexp_t em;
    uexp_t eu;
    forever begin
      @(negedge clk);
      chk("strobe_exclusive", {31'b0, (!rdn && !wrn) || (!ram1EN && (!rdn || !wrn))}, 0);
      if (!rst) begin
        we_n = 0; rdn_n = 0; wrn_n = 0;
        continue;
      end
      if (!ram1WE) we_n++;
      if (!rdn) rdn_n++;
      if (!wrn) begin
        wrn_n++;
        ok = exp_tx.size() != 0;
        chk("tx_pending", {31'b0, ok}, 1);
        if (ok) chk("tx_byte", {24'b0, ram_data1[7:0]}, {24'b0, exp_tx.pop_front()});
      end
      if (!ram1EN && exp_m.size() != 0) chk("ram_addr1", {14'b0, ram_addr1}, {14'b0, exp_m[0].addr});
      if (done_m) begin
        ok = exp_m.size() != 0;
        chk("done_m_pending", {31'b0, ok}, 1);
        if (ok) begin
          em = exp_m.pop_front();
          if (em.rd) chk("rdata_m", {16'b0, rdata_m}, {16'b0, em.v});
          chk("we_low_cycles", we_n, em.rd ? 0 : 1);
        end
        we_n = 0;
        done_log.push_back("M");
      end
      if (done_u) begin
        ok = exp_u.size() != 0;
        chk("done_u_pending", {31'b0, ok}, 1);
        if (ok) begin
          eu = exp_u.pop_front();
          chk("err_u", {31'b0, err_u}, {31'b0, eu.err});
          chk("rdata_u", {24'b0, rdata_u}, {24'b0, eu.v});
          chk("rdn_low_cycles", rdn_n, eu.rdn_n);
          chk("wrn_low_cycles", wrn_n, eu.wrn_n);
        end
        rdn_n = 0; wrn_n = 0;
        done_log.push_back("U");
      end
    end
  end

  initial begin
    int k;
    logic [7:0] order [0:3];
    for (int i = 0; i < 256; i++) begin
      sram[i]    = 16'(i * 37) ^ 16'hC3A5;
      ref_mem[i] = 16'(i * 37) ^ 16'hC3A5;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_rdata_m", {16'b0, rdata_m}, 0);
    chk("rst_rdata_u", {24'b0, rdata_u}, 0);
    chk("rst_ram_addr1", {14'b0, ram_addr1}, 0);
    chk("rst_done_err", {29'b0, done_m, done_u, err_u}, 0);
    chk("rst_strobes", {27'b0, ram1EN, ram1OE, ram1WE, rdn, wrn}, 32'h1F);
    #2 rst = 1'b1;

    // Memory write then read of 0x00012.
    @(posedge clk); #1 issue_m(1'b1, 18'h00012, 16'hBEEF);
    measure(1'b1, k);
    chk("m_write_latency", k, 3);
    @(posedge clk); #1 issue_m(1'b0, 18'h00012, 16'h0000);
    measure(1'b1, k);
    chk("m_read_latency", k, 3);
    chk("m_read_beef", {16'b0, rdata_m}, 32'hBEEF);

    // UART receive with data_ready after 5 cycles.
    @(posedge clk); #1 issue_u(1'b0, 8'h5A, 5, 0);
    measure(1'b0, k);
    chk("rx_byte_5a", {24'b0, rdata_u}, 32'h5A);
    chk("rx_no_err", {31'b0, err_u}, 0);

    // UART transmit 0xA5, tbre after 4, tsre after 8 more.
    @(posedge clk); #1 issue_u(1'b1, 8'hA5, 4, 8);
    measure(1'b0, k);
    chk("tx_no_err", {31'b0, err_u}, 0);

    // Receive timeout: one grant cycle plus WM wait cycles.
    @(posedge clk); #1 issue_u(1'b0, 8'h77, -1, 0);
    measure(1'b0, k);
    chk("rx_timeout_latency", k, WM + 1);
    chk("rx_timeout_err", {31'b0, err_u}, 1);
    chk("rx_timeout_keeps_rdata", {24'b0, rdata_u}, 32'h5A);

    // Reset during M_ACCESS of a write.
    @(posedge clk); #1 issue_m(1'b1, 18'h00034, 16'h1357);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (ram1WE && k < 50);
    chk("reached_m_access", {31'b0, ram1WE}, 0);
    #2 rst = 1'b0;
    req_m = 1'b0;
    mq.delete(); exp_m.delete();
    last_rx = 8'h00;
    #1;
    chk("abort_strobes", {30'b0, ram1WE, ram1EN}, 3);
    chk("abort_no_done", {31'b0, done_m}, 0);
    chk("abort_addr_cleared", {14'b0, ram_addr1}, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    repeat (5) @(negedge clk);

    // Simultaneous requests, two of each.
    @(posedge clk); #1;
    done_log.delete();
    issue_m(1'b0, 18'h00012, 16'h0000);
    issue_u(1'b1, 8'h3C, 1, 1);
    issue_m(1'b1, 18'h00040, 16'h2468);
    issue_u(1'b0, 8'hC7, 2, 0);
    wait_idle(400);
`ifdef ARB_ROUND_ROBIN_EN
    order[0] = "M"; order[1] = "U"; order[2] = "M"; order[3] = "U";
`else
    order[0] = "M"; order[1] = "M"; order[2] = "U"; order[3] = "U";
`endif
    chk("arb_done_count", done_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (done_log.size() > i) chk($sformatf("arb_order_%0d", i), {24'b0, done_log[i]}, {24'b0, order[i]});

    // Randomized traffic on both requesters.
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      issue_m(1'($urandom_range(0, 1)), 18'($urandom) & 18'h3000F, 16'($urandom));
      if ($urandom_range(0, 1) == 1)
        issue_u(1'b1, 8'($urandom),
                ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 8)),
                ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 8)));
      else
        issue_u(1'b0, 8'($urandom),
                ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 8)), 0);
    end
    wait_idle(20000);
    chk("tx_queue_drained", exp_tx.size(), 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
